// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - CSR addresses, mstatus fields, cause codes and ID values shared by the CSR file
package csr_file_pkg;

    // Machine information registers (read-only space)
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Machine trap setup / handling
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;

    // Counters and their user-level read-only shadows
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    // Common synchronous exception codes
    localparam logic [4:0] MCAUSE_INSN_MISALIGNED = 5'd0;
    localparam logic [4:0] MCAUSE_ILLEGAL_INSN    = 5'd2;
    localparam logic [4:0] MCAUSE_BREAKPOINT      = 5'd3;
    localparam logic [4:0] MCAUSE_ECALL_M         = 5'd11;

    // Identification values
    localparam logic [31:0] VENDOR_ID = 32'h0000_0000;
    localparam logic [31:0] ARCH_ID   = 32'h0000_0000;
    localparam logic [31:0] IMPL_ID   = 32'h0000_0001;

    typedef enum logic [1:0] {
        WR_NONE  = 2'b00,
        WR_WRITE = 2'b01,
        WR_SET   = 2'b10,
        WR_CLEAR = 2'b11
    } csr_wr_mode_e;

    // Read-modify-write result for a CSR access; callers truncate to XLEN
    function automatic logic [63:0] csr_modify(input csr_wr_mode_e mode,
                                               input logic [63:0] old_v,
                                               input logic [63:0] data);
        case (mode)
            WR_WRITE: csr_modify = data;
            WR_SET:   csr_modify = old_v | data;
            WR_CLEAR: csr_modify = old_v & ~data;
            default:  csr_modify = old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - 64-bit event counter with per-half write, built only when RV_CSR_COUNTERS_EN is defined
`ifdef RV_CSR_COUNTERS_EN
module csr_counter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [63:0] wr_data_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    // A write to either half takes precedence and suppresses that cycle's increment
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clk_en_i) begin
            if (wr_lo_i || wr_hi_i) begin
                if (wr_lo_i) r_count[31:0]  <= wr_data_i[31:0];
                if (wr_hi_i) r_count[63:32] <= wr_data_i[63:32];
            end else if (inc_i) begin
                r_count <= r_count + 64'd1;
            end
        end
    end

    assign count_o = r_count;

endmodule
`endif

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap entry/return; counters under RV_CSR_COUNTERS_EN
module csr_file
    import csr_file_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     HART_ID      = 0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            rd_i,
    input  logic [11:0]     rd_addr_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_illegal_rd_o,
    output logic            rd_illegal_wr_o,
    input  logic            wr_i,
    input  logic [1:0]      wr_mode_i,
    input  logic [11:0]     wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic            excp_i,
    input  logic [4:0]      excp_cause_i,
    input  logic [XLEN-1:0] excp_pc_i,
    input  logic [XLEN-1:0] excp_tval_i,
    input  logic            mret_i,
    input  logic            retire_i,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o,
    output logic [1:0]      hpl_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic            r_mcause_int;
    logic [4:0]      r_mcause_code;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_rd_data;

    logic            w_rd_impl;
    logic [XLEN-1:0] w_rd_val;
    logic            w_wr_impl;
    logic [XLEN-1:0] w_wr_old;
    logic [XLEN-1:0] w_wr_new;
    logic            w_wr_commit;

`ifdef RV_CSR_COUNTERS_EN
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic        w_cnt_wr;
    logic [63:0] w_cnt_wdata;
`else
    logic        w_unused_retire;
    assign w_unused_retire = retire_i;
`endif

    // Address decode shared by the read port and the write port's old-value lookup
    function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
        logic            impl;
        logic [XLEN-1:0] d;
        impl = 1'b1;
        d    = '0;
        case (addr)
            CSR_MVENDORID: d = XLEN'(VENDOR_ID);
            CSR_MARCHID:   d = XLEN'(ARCH_ID);
            CSR_MIMPID:    d = XLEN'(IMPL_ID);
            CSR_MHARTID:   d = XLEN'(HART_ID);
            CSR_MSTATUS: begin
                d[MSTATUS_MIE_BIT]                    = r_mie;
                d[MSTATUS_MPIE_BIT]                   = r_mpie;
                d[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]  = 2'b11;
            end
            CSR_MTVEC:     d = r_mtvec;
            CSR_MSCRATCH:  d = r_mscratch;
            CSR_MEPC:      d = r_mepc;
            CSR_MCAUSE: begin
                d[XLEN-1] = r_mcause_int;
                d[4:0]    = r_mcause_code;
            end
            CSR_MTVAL:     d = r_mtval;
`ifdef RV_CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_CYCLE:     d = w_mcycle[XLEN-1:0];
            CSR_MINSTRET, CSR_INSTRET: d = w_minstret[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: begin
                impl = (XLEN == 32);
                if (XLEN == 32) d = XLEN'(w_mcycle[63:32]);
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                impl = (XLEN == 32);
                if (XLEN == 32) d = XLEN'(w_minstret[63:32]);
            end
`endif
            default: impl = 1'b0;
        endcase
        csr_lookup = {impl, d};
    endfunction

    // Read-side decode and illegal-access flags
    always_comb begin
        {w_rd_impl, w_rd_val} = csr_lookup(rd_addr_i);
        rd_illegal_rd_o       = ~w_rd_impl;
        rd_illegal_wr_o       = ~w_rd_impl | (rd_addr_i[11:10] == 2'b11);
    end

    // Write-side old value, modified value and commit qualification
    always_comb begin
        {w_wr_impl, w_wr_old} = csr_lookup(wr_addr_i);
        w_wr_new    = XLEN'(csr_modify(csr_wr_mode_e'(wr_mode_i), 64'(w_wr_old), 64'(wr_data_i)));
        w_wr_commit = wr_i & clk_en_i & (wr_mode_i != WR_NONE) & w_wr_impl
                    & (wr_addr_i[11:10] != 2'b11);
    end

    // Architectural state: reset first, then trap entry > mret > CSR write
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_mtvec       <= RESET_VECTOR & ALIGN_MASK;
            r_mscratch    <= '0;
            r_mepc        <= '0;
            r_mcause_int  <= 1'b0;
            r_mcause_code <= '0;
            r_mtval       <= '0;
            r_rd_data     <= '0;
        end else if (clk_en_i) begin
            if (rd_i) r_rd_data <= w_rd_val;
            if (excp_i) begin
                r_mepc        <= excp_pc_i & ALIGN_MASK;
                r_mcause_int  <= 1'b0;
                r_mcause_code <= excp_cause_i;
                r_mtval       <= excp_tval_i;
                r_mpie        <= r_mie;
                r_mie         <= 1'b0;
            end else if (mret_i) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr_commit) begin
                case (wr_addr_i)
                    CSR_MSTATUS: begin
                        r_mie  <= w_wr_new[MSTATUS_MIE_BIT];
                        r_mpie <= w_wr_new[MSTATUS_MPIE_BIT];
                    end
                    CSR_MTVEC:    r_mtvec    <= w_wr_new & ALIGN_MASK;
                    CSR_MSCRATCH: r_mscratch <= w_wr_new;
                    CSR_MEPC:     r_mepc     <= w_wr_new & ALIGN_MASK;
                    CSR_MCAUSE: begin
                        r_mcause_int  <= w_wr_new[XLEN-1];
                        r_mcause_code <= w_wr_new[4:0];
                    end
                    CSR_MTVAL:    r_mtval    <= w_wr_new;
                    default: ;
                endcase
            end
        end
    end

`ifdef RV_CSR_COUNTERS_EN
    // Counter writes lose to trap entry and mret like every other CSR write
    assign w_cnt_wr    = w_wr_commit & ~excp_i & ~mret_i;
    assign w_cnt_wdata = {w_wr_new[XLEN-1 -: 32], w_wr_new[31:0]};

    csr_counter u_mcycle (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clk_en_i  (clk_en_i),
        .inc_i     (1'b1),
        .wr_lo_i   (w_cnt_wr & (wr_addr_i == CSR_MCYCLE)),
        .wr_hi_i   (w_cnt_wr & ((wr_addr_i == CSR_MCYCLEH) |
                               ((XLEN == 64) & (wr_addr_i == CSR_MCYCLE)))),
        .wr_data_i (w_cnt_wdata),
        .count_o   (w_mcycle)
    );

    csr_counter u_minstret (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clk_en_i  (clk_en_i),
        .inc_i     (retire_i),
        .wr_lo_i   (w_cnt_wr & (wr_addr_i == CSR_MINSTRET)),
        .wr_hi_i   (w_cnt_wr & ((wr_addr_i == CSR_MINSTRETH) |
                               ((XLEN == 64) & (wr_addr_i == CSR_MINSTRET)))),
        .wr_data_i (w_cnt_wdata),
        .count_o   (w_minstret)
    );
`endif

    assign rd_data_o  = r_rd_data;
    assign trap_vec_o = {r_mtvec[XLEN-1:2], 2'b00};
    assign mepc_o     = r_mepc;
    assign mie_o      = r_mie;
    assign hpl_o      = 2'b11;

endmodule
